// File: rtl/fx16_band_combiner_pkg.sv
// Shared constants and types for the fx16 band combiner.
// Holds the band count, Q1.15 format widths, saturation limit,
// accumulator width and the controller state encoding.
package fx16_band_combiner_pkg;

  localparam int NUM_BANDS = 4;
  localparam int Q_W       = 16;
  localparam int FRAC_W    = 15;
  localparam int ACC_W     = 18;

  localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/fx16_sm_mult.sv
// Sign-magnitude Q1.15 multiplier, purely combinational.
// Ports: a, b - sign-magnitude Q1.15 operands; p - sign-magnitude Q1.15 product.
// Magnitude truncates toward zero; a zero magnitude always carries a + sign.
module fx16_sm_mult
  import fx16_band_combiner_pkg::*;
(
  input  logic [Q_W-1:0] a,
  input  logic [Q_W-1:0] b,
  output logic [Q_W-1:0] p
);

  logic [2*FRAC_W-1:0] full;
  logic [FRAC_W-1:0]   mag;

  assign full = a[FRAC_W-1:0] * b[FRAC_W-1:0];
  assign mag  = full[2*FRAC_W-1:FRAC_W];

  // Suppress the sign on a zero magnitude so no negative zero escapes.
  assign p = {(a[Q_W-1] ^ b[Q_W-1]) & (|mag), mag};

endmodule

// File: rtl/fx16_band_combiner.sv
// Combines four sign-magnitude Q1.15 band samples, each scaled by its own gain,
// into one saturated sign-magnitude Q1.15 output using a single shared multiplier.
// Ports: clk_slow/rst (sync, active-low); band0_in..band3_in + in_valid/in_ready
// input handshake; gain_wr/gain_sel/gain_data gain writes; fir_out + out_valid/out_ready.
// Latency 5 cycles accept-to-out_valid; out_valid/fir_out hold while out_ready is low.
module fx16_band_combiner #(
  parameter int          NUM_BANDS = fx16_band_combiner_pkg::NUM_BANDS,
  parameter logic [15:0] GAIN_RST  = 16'h7FFF
) (
  input  logic        clk_slow,
  input  logic        rst,
  input  logic [15:0] band0_in,
  input  logic [15:0] band1_in,
  input  logic [15:0] band2_in,
  input  logic [15:0] band3_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        gain_wr,
  input  logic [1:0]  gain_sel,
  input  logic [15:0] gain_data,
  output logic [15:0] fir_out,
  output logic        out_valid,
  input  logic        out_ready
);

  import fx16_band_combiner_pkg::*;

  localparam int IDX_W = $clog2(NUM_BANDS);
  // One extra count value marks the finalize cycle after the last product.
  localparam int CNT_W = $clog2(NUM_BANDS + 1);

  localparam logic signed [ACC_W-1:0] POS_LIM = $signed({{(ACC_W-Q_W){1'b0}}, SAT_MAX});
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  state_t                  state;
  logic [CNT_W-1:0]        mac_cnt;
  logic signed [ACC_W-1:0] acc;
  logic [Q_W-1:0]          band_q   [NUM_BANDS];
  logic [Q_W-1:0]          gain_q   [NUM_BANDS];
  logic [Q_W-1:0]          shadow_q [NUM_BANDS];
  logic [Q_W-1:0]          band_in  [NUM_BANDS];

  logic [IDX_W-1:0]        mac_idx;
  logic [Q_W-1:0]          prod_sm;
  logic signed [ACC_W-1:0] prod_s;
  logic signed [ACC_W-1:0] acc_neg;
  logic [Q_W-1:0]          sat_sm;

  assign band_in[0] = band0_in;
  assign band_in[1] = band1_in;
  assign band_in[2] = band2_in;
  assign band_in[3] = band3_in;

  assign in_ready = (state == ST_IDLE);
  assign mac_idx  = mac_cnt[IDX_W-1:0];

  fx16_sm_mult u_mult (
    .a (band_q[mac_idx]),
    .b (shadow_q[mac_idx]),
    .p (prod_sm)
  );

  // Sign-magnitude product into two's complement for accumulation.
  assign prod_s  = prod_sm[Q_W-1] ? -$signed({{(ACC_W-FRAC_W){1'b0}}, prod_sm[FRAC_W-1:0]})
                                  :  $signed({{(ACC_W-FRAC_W){1'b0}}, prod_sm[FRAC_W-1:0]});
  assign acc_neg = -acc;

  // Saturate to +/-32767 and convert back to sign-magnitude; zero stays positive.
  always_comb begin
    sat_sm = '0;
    if (acc > POS_LIM)
      sat_sm = SAT_MAX;
    else if (acc < NEG_LIM)
      sat_sm = {1'b1, SAT_MAX[FRAC_W-1:0]};
    else if (acc < 0)
      sat_sm = {1'b1, acc_neg[FRAC_W-1:0]};
    else
      sat_sm = {1'b0, acc[FRAC_W-1:0]};
  end

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mac_cnt   <= '0;
      acc       <= '0;
      fir_out   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        band_q[i]   <= '0;
        gain_q[i]   <= GAIN_RST;
        shadow_q[i] <= GAIN_RST;
      end
    end else begin
      // Shadows sample gain_q before this write lands, so a write coincident
      // with an accept only affects the following sample.
      if (gain_wr)
        gain_q[gain_sel] <= gain_data;

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              band_q[i]   <= band_in[i];
              shadow_q[i] <= gain_q[i];
            end
            acc     <= '0;
            mac_cnt <= '0;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (mac_cnt == CNT_W'(NUM_BANDS)) begin
            fir_out   <= sat_sm;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            acc     <= acc + prod_s;
            mac_cnt <= mac_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx16_band_combiner.sv
// Directed self-checking bench for fx16_band_combiner.
// Each vector carries a hand-computed sign-magnitude Q1.15 result.
// Covers reset, saturation, zero sign, backpressure, gain timing and mid-MAC reset.
module tb_fx16_band_combiner;

  logic        clk_slow = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] band0_in = '0, band1_in = '0, band2_in = '0, band3_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        gain_wr = 1'b0;
  logic [1:0]  gain_sel = '0;
  logic [15:0] gain_data = '0;
  logic [15:0] fir_out;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  fx16_band_combiner dut (
    .clk_slow  (clk_slow),
    .rst       (rst),
    .band0_in  (band0_in),
    .band1_in  (band1_in),
    .band2_in  (band2_in),
    .band3_in  (band3_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gain_wr   (gain_wr),
    .gain_sel  (gain_sel),
    .gain_data (gain_data),
    .fir_out   (fir_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_slow);
    #1;
  endtask

  // Present a sample set while idle; it is accepted at the next edge.
  task automatic start_sample(input string tag, input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] b2, input logic [15:0] b3);
    check_eq({tag, " in_ready"}, in_ready, 1);
    band0_in = b0; band1_in = b1; band2_in = b2; band3_in = b3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    gain_wr  = 1'b0;
  endtask

  // Bounded wait for out_valid; the accept edge is E0, so out_valid must rise at E5.
  task automatic wait_out(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, lat, 5);
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, " out_valid clear"}, out_valid, 0);
  endtask

  task automatic run_sample(input string tag, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input logic [15:0] b3, input logic [15:0] exp);
    start_sample(tag, b0, b1, b2, b3);
    wait_out(tag);
    check_eq({tag, " fir_out"}, fir_out, exp);
    take_out(tag);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst out_valid", out_valid, 0);
    check_eq("rst fir_out", fir_out, 16'h0000);
    check_eq("rst in_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // 0.5 * 0.99997 -> 16383.5 truncated
    run_sample("half", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFF);
    // 4 * 32766 = 131064 -> positive saturation
    run_sample("sat_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    // 4 * -32766 -> negative saturation
    run_sample("sat_neg", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    // +8191 - 8191 = 0, must not become 8000
    run_sample("zero", 16'h2000, 16'hA000, 16'h0000, 16'h0000, 16'h0000);
    // -0.5 on band1 -> -16383
    run_sample("neg", 16'h0000, 16'hC000, 16'h0000, 16'h0000, 16'hBFFF);
    // negative-zero band input gives a +0 product
    run_sample("negzero_in", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000);

    // Backpressure: result held, new in_valid ignored until the output handshake.
    start_sample("bp", 16'h2000, 16'h0000, 16'h0000, 16'h0000);
    wait_out("bp");
    check_eq("bp fir_out", fir_out, 16'h1FFF);
    band0_in = 16'h1000; band1_in = 16'h1000; band2_in = 16'h1000; band3_in = 16'h1000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp hold fir_out", fir_out, 16'h1FFF);
      check_eq("bp hold out_valid", out_valid, 1);
      check_eq("bp hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp release out_valid", out_valid, 0);
    check_eq("bp release in_ready", in_ready, 1);
    check_eq("bp retain fir_out", fir_out, 16'h1FFF);
    tick();
    in_valid = 1'b0;
    wait_out("bp next");
    // 4 * (4096*32767 >> 15) = 4 * 4095
    check_eq("bp next fir_out", fir_out, 16'h3FFC);
    take_out("bp next");

    // Gain write coincident with accept: old gain used now, new gain next time.
    gain_wr = 1'b1; gain_sel = 2'd0; gain_data = 16'h4000;
    run_sample("gw same", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFF);
    run_sample("gw next", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h2000);

    // Negative gain written while idle applies to the next sample.
    gain_wr = 1'b1; gain_sel = 2'd2; gain_data = 16'hC000;
    tick();
    gain_wr = 1'b0;
    run_sample("gneg", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'hA000);

    // Reset in the middle of MAC abandons the sample and restores gains.
    start_sample("mid rst", 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("mid rst out_valid", out_valid, 0);
    check_eq("mid rst fir_out", fir_out, 16'h0000);
    check_eq("mid rst in_ready", in_ready, 1);
    repeat (6) tick();
    check_eq("mid rst no output", out_valid, 0);
    run_sample("post rst gain0", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFF);
    run_sample("post rst gain2", 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h3FFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
